// File: rtl/rx_order_tagger.sv
// rx_order_tagger
//   Classifies completed, error-free OUT/IN/SETUP/DATA packets and pushes one
//   8-bit order tag {type[1:0], seq[5:0]} per packet into the packet-order FIFO.
//   A tag that meets a full FIFO waits up to MAX_WAIT stall cycles, then is
//   dropped; the drop sets the sticky overflow flag.
//
// Ports
//   clk        system clock
//   n_rst      asynchronous reset, active-high (despite the name)
//   pid_valid  start-of-packet strobe, rx_pid valid
//   rx_pid     low nibble of the PID byte
//   eop        end-of-packet strobe
//   crc_ok     CRC result, sampled with eop
//   rx_error   bit-stuff / sync / framing error strobe
//   fifo_full  order FIFO full flag
//   w_enable   FIFO write strobe, one cycle per tag
//   w_data     tag; holds the last written value between writes
//   overflow   sticky, set when a tag is dropped
//   err_count  saturating count of aborted packets
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for a packet start
// IN_PKT  | inside a taggable packet, waiting for eop / error
// SKIP    | inside a non-taggable packet, waiting for its end
// PUSH    | packet accepted, first attempt to write the tag
// STALL   | FIFO full, retrying the write until MAX_WAIT expires

module rx_order_tagger #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       pid_valid,
    input  logic [3:0] rx_pid,
    input  logic       eop,
    input  logic       crc_ok,
    input  logic       rx_error,
    input  logic       fifo_full,
    output logic       w_enable,
    output logic [7:0] w_data,
    output logic       overflow,
    output logic [7:0] err_count
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_IN_PKT = 3'd1;
    localparam logic [2:0] ST_SKIP   = 3'd2;
    localparam logic [2:0] ST_PUSH   = 3'd3;
    localparam logic [2:0] ST_STALL  = 3'd4;

    // Last stall-counter value before the tag is dropped.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    logic [2:0] state, state_nxt;
    logic [1:0] pkt_type, pkt_type_nxt;
    logic [5:0] seq;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic [7:0] last_data;
    logic       taggable;
    logic [1:0] pid_type;
    logic       err_inc;
    logic       do_write;
    logic       do_drop;

    always_comb begin
        taggable = 1'b1;
        pid_type = 2'b00;
        case (rx_pid)
            4'b0001: pid_type = 2'b00;
            4'b1001: pid_type = 2'b01;
            4'b1101: pid_type = 2'b10;
            4'b0011,
            4'b1011: pid_type = 2'b11;
            default: taggable = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt    = state;
        pkt_type_nxt = pkt_type;
        wait_cnt_nxt = wait_cnt;
        err_inc      = 1'b0;
        do_write     = 1'b0;
        do_drop      = 1'b0;
        case (state)
            ST_IDLE, ST_SKIP: begin
                if (pid_valid) begin
                    state_nxt    = taggable ? ST_IN_PKT : ST_SKIP;
                    pkt_type_nxt = taggable ? pid_type : pkt_type;
                end else if (state == ST_SKIP && (eop || rx_error)) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_IN_PKT: begin
                if (pid_valid) begin
                    // Missing end of the previous packet: count it, then
                    // treat the new PID as a fresh start.
                    err_inc      = 1'b1;
                    state_nxt    = taggable ? ST_IN_PKT : ST_SKIP;
                    pkt_type_nxt = taggable ? pid_type : pkt_type;
                end else if (rx_error || (eop && !crc_ok)) begin
                    err_inc   = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (eop) begin
                    state_nxt = ST_PUSH;
                end
            end
            ST_PUSH: begin
                err_inc = pid_valid;
                if (!fifo_full) begin
                    do_write  = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    wait_cnt_nxt = 8'd0;
                    state_nxt    = ST_STALL;
                end
            end
            ST_STALL: begin
                err_inc = pid_valid;
                if (!fifo_full) begin
                    do_write  = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    do_drop   = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Write strobe comes straight from state so the FIFO sees it in the same
    // cycle fifo_full is observed low; no stale write after full rises.
    assign w_enable = do_write;
    assign w_data   = do_write ? {pkt_type, seq} : last_data;

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            state     <= ST_IDLE;
            pkt_type  <= 2'b00;
            seq       <= 6'd0;
            wait_cnt  <= 8'd0;
            last_data <= 8'd0;
            overflow  <= 1'b0;
            err_count <= 8'd0;
        end else begin
            state    <= state_nxt;
            pkt_type <= pkt_type_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (do_write) begin
                last_data <= {pkt_type, seq};
            end
            // Dropped tags still consume a sequence number so the gap shows.
            if (do_write || do_drop) begin
                seq <= seq + 6'd1;
            end
            if (do_drop) begin
                overflow <= 1'b1;
            end
            if (err_inc && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_rx_order_tagger.sv
// tb_rx_order_tagger
//   Directed bench for rx_order_tagger: a table of single packets with
//   hand-computed tags, then hand-written sequences for sequence wrap,
//   FIFO stall, tag drop and asynchronous reset in the middle of a stall.

module tb_rx_order_tagger;

    logic       clk = 1'b0;
    logic       n_rst = 1'b1;
    logic       pid_valid = 1'b0;
    logic [3:0] rx_pid = 4'd0;
    logic       eop = 1'b0;
    logic       crc_ok = 1'b0;
    logic       rx_error = 1'b0;
    logic       fifo_full = 1'b0;
    logic       w_enable;
    logic [7:0] w_data;
    logic       overflow;
    logic [7:0] err_count;

    rx_order_tagger #(.MAX_WAIT(15)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .pid_valid (pid_valid),
        .rx_pid    (rx_pid),
        .eop       (eop),
        .crc_ok    (crc_ok),
        .rx_error  (rx_error),
        .fifo_full (fifo_full),
        .w_enable  (w_enable),
        .w_data    (w_data),
        .overflow  (overflow),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Write monitor, sampled away from the rising edge.
    int         cyc = 0;
    int         wr_cnt = 0;
    int         wr_cyc = 0;
    logic [7:0] wr_last = 8'd0;
    int         eop_cyc = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (w_enable) begin
            wr_cnt  = wr_cnt + 1;
            wr_cyc  = cyc;
            wr_last = w_data;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #1;
        n_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b0;
        idle(1);
    endtask

    // pid cycle, one body cycle (optional rx_error), eop cycle; returns one
    // cycle after eop, i.e. in the cycle where the write is expected.
    task automatic send_pkt(input logic [3:0] pid, input logic crc, input logic err_mid);
        @(posedge clk); #1;
        pid_valid = 1'b1;
        rx_pid    = pid;
        @(posedge clk); #1;
        pid_valid = 1'b0;
        rx_error  = err_mid;
        @(posedge clk); #1;
        rx_error = 1'b0;
        eop      = 1'b1;
        crc_ok   = crc;
        eop_cyc  = cyc + 1;
        @(posedge clk); #1;
        eop    = 1'b0;
        crc_ok = 1'b0;
    endtask

    typedef struct {
        logic [3:0] pid;
        logic       crc;
        logic       err_mid;
        int         exp_wr;
        logic [7:0] exp_data;
        logic [7:0] exp_err;
    } vec_t;

    vec_t vecs[9];
    int   w0;

    initial begin
        vecs[0] = '{4'b1101, 1'b1, 1'b0, 1, 8'h80, 8'd0}; // SETUP seq0
        vecs[1] = '{4'b0001, 1'b1, 1'b0, 1, 8'h01, 8'd0}; // OUT seq1
        vecs[2] = '{4'b1001, 1'b0, 1'b0, 0, 8'h00, 8'd1}; // IN, CRC fail
        vecs[3] = '{4'b0001, 1'b1, 1'b1, 0, 8'h00, 8'd2}; // OUT, rx_error
        vecs[4] = '{4'b0010, 1'b1, 1'b0, 0, 8'h00, 8'd2}; // ACK, untagged
        vecs[5] = '{4'b1011, 1'b1, 1'b0, 1, 8'hC2, 8'd2}; // DATA1 seq2
        vecs[6] = '{4'b1001, 1'b1, 1'b0, 1, 8'h43, 8'd2}; // IN seq3
        vecs[7] = '{4'b0011, 1'b1, 1'b0, 1, 8'hC4, 8'd2}; // DATA0 seq4
        vecs[8] = '{4'b0101, 1'b1, 1'b0, 0, 8'h00, 8'd2}; // SOF, untagged

        idle(2);
        chk("rst_w_enable", int'(w_enable), 0);
        chk("rst_w_data", int'(w_data), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_err_count", int'(err_count), 0);
        n_rst = 1'b0;
        idle(2);

        for (int i = 0; i < 9; i++) begin
            w0 = wr_cnt;
            send_pkt(vecs[i].pid, vecs[i].crc, vecs[i].err_mid);
            idle(3);
            chk($sformatf("tbl%0d_wr_cnt", i), wr_cnt - w0, vecs[i].exp_wr);
            if (vecs[i].exp_wr == 1) begin
                chk($sformatf("tbl%0d_w_data", i), int'(wr_last), int'(vecs[i].exp_data));
                chk($sformatf("tbl%0d_latency", i), wr_cyc - eop_cyc, 1);
            end
            chk($sformatf("tbl%0d_err_count", i), int'(err_count), int'(vecs[i].exp_err));
        end
        chk("tbl_hold_w_data", int'(w_data), 8'hC4);

        // Second PID before eop: counted as error, new IN packet tagged.
        w0 = wr_cnt;
        @(posedge clk); #1; pid_valid = 1'b1; rx_pid = 4'b0001;
        @(posedge clk); #1; rx_pid = 4'b1001;
        @(posedge clk); #1; pid_valid = 1'b0; eop = 1'b1; crc_ok = 1'b1;
        @(posedge clk); #1; eop = 1'b0; crc_ok = 1'b0;
        idle(2);
        chk("reeval_wr_cnt", wr_cnt - w0, 1);
        chk("reeval_w_data", int'(wr_last), 8'h45);
        chk("reeval_err_count", int'(err_count), 3);

        // 65 DATA0 packets: seq runs 0..63 then wraps to 0.
        do_reset();
        for (int i = 0; i < 65; i++) begin
            w0 = wr_cnt;
            send_pkt(4'b0011, 1'b1, 1'b0);
            idle(2);
            chk($sformatf("wrap%0d_wr_cnt", i), wr_cnt - w0, 1);
            chk($sformatf("wrap%0d_w_data", i), int'(wr_last), 8'hC0 | (i % 64));
        end

        // FIFO released 5 cycles after eop: single write on the release cycle.
        do_reset();
        fifo_full = 1'b1;
        w0 = wr_cnt;
        send_pkt(4'b0001, 1'b1, 1'b0);
        idle(4);
        chk("stall_no_early_wr", wr_cnt - w0, 0);
        fifo_full = 1'b0;
        idle(3);
        chk("stall_wr_cnt", wr_cnt - w0, 1);
        chk("stall_w_data", int'(wr_last), 8'h00);
        chk("stall_latency", wr_cyc - eop_cyc, 5);
        chk("stall_overflow", int'(overflow), 0);

        // FIFO held for 20 cycles: tag dropped after 15 stall cycles.
        do_reset();
        fifo_full = 1'b1;
        w0 = wr_cnt;
        send_pkt(4'b0001, 1'b1, 1'b0);
        idle(14);
        chk("drop_overflow_before", int'(overflow), 0);
        idle(2);
        chk("drop_overflow_after", int'(overflow), 1);
        idle(3);
        fifo_full = 1'b0;
        idle(2);
        chk("drop_wr_cnt", wr_cnt - w0, 0);
        w0 = wr_cnt;
        send_pkt(4'b0001, 1'b1, 1'b0);
        idle(2);
        chk("drop_next_wr_cnt", wr_cnt - w0, 1);
        chk("drop_next_w_data", int'(wr_last), 8'h01);
        chk("drop_overflow_sticky", int'(overflow), 1);

        // Reset asserted while stalled clears everything at once.
        send_pkt(4'b1001, 1'b0, 1'b0);
        idle(1);
        chk("mid_err_before", int'(err_count), 1);
        fifo_full = 1'b1;
        w0 = wr_cnt;
        send_pkt(4'b0001, 1'b1, 1'b0);
        idle(3);
        #2;
        n_rst = 1'b1;
        #1;
        chk("mid_rst_w_enable", int'(w_enable), 0);
        chk("mid_rst_overflow", int'(overflow), 0);
        chk("mid_rst_err_count", int'(err_count), 0);
        fifo_full = 1'b0;
        idle(2);
        n_rst = 1'b0;
        idle(2);
        chk("mid_rst_no_write", wr_cnt - w0, 0);
        w0 = wr_cnt;
        send_pkt(4'b0001, 1'b1, 1'b0);
        idle(2);
        chk("post_rst_wr_cnt", wr_cnt - w0, 1);
        chk("post_rst_w_data", int'(wr_last), 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rx_order_tagger.md
Name: rx_order_tagger

Overview:
- Sits directly upstream of the receiver's packet-order FIFO (8-bit wide, 4 entries deep). It is that FIFO's only writer.
- Watches decoded USB packet events and classifies each completed, error-free OUT/IN/SETUP/DATA packet.
- Pushes one 8-bit order tag per accepted packet into the FIFO, so downstream logic can replay arrival order.
- Handles FIFO back-pressure with a bounded stall, then drops the tag and flags overflow.

Parameters:
- MAX_WAIT, 15: maximum cycles a completed tag waits on fifo_full before it is dropped (1..255).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- n_rst  input  1  asynchronous reset, active-high: asserted when n_rst=1, clears all state immediately.
- pid_valid  input  1  one-cycle strobe; rx_pid is valid this cycle (start of packet).
- rx_pid  input  4  low nibble of the received PID byte.
- eop  input  1  one-cycle strobe; end of current packet.
- crc_ok  input  1  sampled only with eop; 1 = packet CRC passed.
- rx_error  input  1  one-cycle strobe; bit-stuff, sync or framing error in the current packet.
- fifo_full  input  1  full flag from the order FIFO.
- w_enable  output  1  FIFO write strobe, exactly one cycle per tag.
- w_data  output  8  tag = {type[1:0], seq[5:0]}.
- overflow  output  1  sticky; set when a tag is dropped.
- err_count  output  8  count of packets aborted by rx_error or CRC failure; saturates at 255.

Behaviour:
- Reset values: w_enable=0, w_data=0, overflow=0, err_count=0, seq=0, state=IDLE, wait counter=0.
- PID classification on rx_pid:
  - 0001 OUT -> type 00
  - 1001 IN -> type 01
  - 1101 SETUP -> type 10
  - 0011 DATA0 and 1011 DATA1 -> type 11
  - Any other PID is not tagged.
- States: IDLE, IN_PKT, SKIP, PUSH, STALL.
- IDLE:
  - pid_valid with a taggable PID: latch type, go to IN_PKT.
  - pid_valid with a non-taggable PID: go to SKIP.
  - eop or rx_error with no pid_valid: ignored.
- SKIP: wait for eop or rx_error, then return to IDLE. No tag, no count change.
- IN_PKT:
  - rx_error: increment err_count, go to IDLE.
  - eop with crc_ok=1: go to PUSH.
  - eop with crc_ok=0: increment err_count, go to IDLE.
  - rx_error and eop in the same cycle: treat as an error.
  - A new pid_valid while in IN_PKT is a framing fault: increment err_count, then re-evaluate the new PID exactly as in IDLE, in the same cycle.
- PUSH:
  - fifo_full=0: w_enable=1 for one cycle with w_data={type, seq}; seq increments modulo 64 (63 -> 0); go to IDLE.
  - fifo_full=1: go to STALL with wait counter=0.
  - Latency: w_enable asserts 1 cycle after the eop cycle when the FIFO is not full.
- STALL:
  - Each cycle, if fifo_full=0: write the tag (as in PUSH) and go to IDLE.
  - Otherwise increment the wait counter. When it reaches MAX_WAIT, drop the tag: no write, overflow set to 1, seq still increments so the gap is visible, go to IDLE.
  - pid_valid in PUSH/STALL: the packet is ignored entirely and err_count increments.
- w_data holds its last written value between writes. It is meaningful only while w_enable=1.
- overflow clears only on reset.
- Reset asserted mid-packet or mid-stall: all state returns to reset values asynchronously. No partial write may occur.

Test Plan:
- Reset, then pid_valid with rx_pid=1101, then eop with crc_ok=1 two cycles later, fifo_full=0 -> one-cycle w_enable on the cycle after eop, w_data=0x80; the next tag carries seq=1.
- Send 64 accepted DATA0 packets -> w_data runs 0xC0..0xFF; the 65th packet gives w_data=0xC0 (wrap).
- IN packet with eop and crc_ok=0, then OUT packet with an rx_error pulse mid-packet -> no w_enable, err_count=2. An ACK PID (0010) followed by eop -> no write, err_count unchanged.
- fifo_full=1 held, OUT packet completes, fifo_full released 5 cycles after eop -> single write of 0x00 on the release cycle, overflow=0.
- fifo_full held for 20 cycles after eop with MAX_WAIT=15 -> no write, overflow=1. The next accepted OUT packet writes 0x01 (seq skipped 0).
- Assert n_rst while in STALL -> w_enable=0, overflow=0, err_count=0 immediately. The first packet after release gets seq=0.
